// File: rtl/switch_allocator_if.sv
// Switch allocator request/grant bundle: per-input head-flit requests,
// per-output readiness, and the crossbar select/enable/grant responses.
interface switch_allocator_if #(
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned NUM_OUT = 5
);
  localparam int unsigned SEL_W = $clog2(NUM_IN) + ((NUM_IN == 1) ? 1 : 0);
  localparam int unsigned DST_W = $clog2(NUM_OUT) + ((NUM_OUT == 1) ? 1 : 0);

  logic [NUM_IN-1:0]             req_valid;
  logic [NUM_IN-1:0][DST_W-1:0]  req_dst;
  logic [NUM_IN-1:0]             req_tail;
  logic [NUM_OUT-1:0]            out_ready;
  logic [NUM_OUT-1:0][SEL_W-1:0] sel;
  logic [NUM_OUT-1:0]            enable;
  logic [NUM_IN-1:0]             grant;

  modport master (
    output req_valid, req_dst, req_tail, out_ready,
    input  sel, enable, grant
  );

  modport slave (
    input  req_valid, req_dst, req_tail, out_ready,
    output sel, enable, grant
  );
endinterface

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter per output that locks
// onto the winning input until that packet's tail flit has transferred.
module switch_allocator #(
  parameter int unsigned NUM_IN  = 5,
  parameter int unsigned NUM_OUT = 5
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_IN) + ((NUM_IN == 1) ? 1 : 0);
  localparam int unsigned DST_W = $clog2(NUM_OUT) + ((NUM_OUT == 1) ? 1 : 0);
  // After reset input 0 is the first one scanned.
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_IN - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state [NUM_OUT];
  logic [SEL_W-1:0] owner [NUM_OUT];
  logic [SEL_W-1:0] ptr   [NUM_OUT];

  logic [NUM_OUT-1:0][NUM_IN-1:0] hit;
  logic [NUM_OUT-1:0][SEL_W-1:0]  src_c;
  logic [NUM_OUT-1:0][SEL_W-1:0]  sel_c;
  logic [NUM_OUT-1:0]             xfer_c;
  logic [NUM_OUT-1:0]             tail_c;
  logic [NUM_IN-1:0]              grant_c;

  // Request matrix; destinations at or above NUM_OUT match no output.
  always_comb begin
    hit = '0;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      for (int i = 0; i < int'(NUM_IN); i++) begin
        hit[o][i] = bus.req_valid[i] && (bus.req_dst[i] == DST_W'(o));
      end
    end
  end

  // Per-output winner selection and transfer decision for this cycle.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] cand;
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    xfer_c  = '0;
    tail_c  = '0;
    src_c   = '0;
    sel_c   = '0;
    grant_c = '0;
    for (int o = 0; o < int'(NUM_OUT); o++) begin
      if (state[o] == LOCKED) begin
        sel_c[o] = owner[o];
        if (hit[o][owner[o]] && bus.out_ready[o]) begin
          xfer_c[o] = 1'b1;
          src_c[o]  = owner[o];
        end
      end else begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= int'(NUM_IN); k++) begin
          cand = SEL_W'((int'(ptr[o]) + k) % int'(NUM_IN));
          if (!found && hit[o][cand]) begin
            found = 1'b1;
            win   = cand;
          end
        end
        if (found && bus.out_ready[o]) begin
          xfer_c[o] = 1'b1;
          src_c[o]  = win;
          sel_c[o]  = win;
        end
      end
      if (xfer_c[o]) begin
        grant_c[src_c[o]] = 1'b1;
        tail_c[o]         = bus.req_tail[src_c[o]];
      end
    end
  end

  // Crossbar controls are combinational so allocation costs no cycle.
  always_comb begin
    bus.sel    = sel_c;
    bus.enable = xfer_c;
    bus.grant  = grant_c;
  end

  // Lock on a packet's head flit, release and advance the pointer on its tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < int'(NUM_OUT); o++) begin
        state[o] <= IDLE;
        owner[o] <= '0;
        ptr[o]   <= PTR_RST;
      end
    end else begin
      for (int o = 0; o < int'(NUM_OUT); o++) begin
        if (state[o] == IDLE) begin
          if (xfer_c[o]) begin
            if (tail_c[o]) begin
              ptr[o] <= src_c[o];
            end else begin
              state[o] <= LOCKED;
              owner[o] <= src_c[o];
            end
          end
        end else if (xfer_c[o] && tail_c[o]) begin
          state[o] <= IDLE;
          ptr[o]   <= owner[o];
        end
      end
    end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: a packet-level reference model
// predicts enable/grant/sel each cycle, a negedge monitor compares.
module tb_switch_allocator;
  localparam int unsigned NI    = 5;
  localparam int unsigned NO    = 5;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned DST_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  switch_allocator_if #(.NUM_IN(NI), .NUM_OUT(NO)) bus ();

  switch_allocator #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int dst;
    bit tail;
  } flit_t;

  typedef struct {
    logic [NO-1:0]            en;
    logic [NI-1:0]            gr;
    logic [NO-1:0][SEL_W-1:0] sel;
  } exp_t;

  flit_t fq [NI][$];
  int    age [NI];
  int    lock_own [NO];
  int    last_srv [NO];
  exp_t  exp_q [$];
  exp_t  mon_e;
  int    n_chk  = 0;
  int    n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
  endtask

  task automatic model_reset();
    for (int o = 0; o < int'(NO); o++) begin
      lock_own[o] = -1;
      last_srv[o] = int'(NI) - 1;
    end
    for (int i = 0; i < int'(NI); i++) begin
      fq[i].delete();
      age[i] = 0;
    end
  endtask

  task automatic add_pkt(input int src, input int dst, input int len);
    for (int f = 0; f < len; f++) begin
      flit_t x;
      x.dst  = dst;
      x.tail = (f == len - 1);
      fq[src].push_back(x);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < int'(NI); i++) n += fq[i].size();
    return n;
  endfunction

  // One clock: drive heads of queues, predict the response, retire granted flits.
  task automatic step(input logic r, input logic [NO-1:0] rdy, input logic [NI-1:0] pres);
    exp_t e;
    bit   v [NI];
    int   d [NI];
    bit   t [NI];
    int   w;
    int   c;
    @(posedge clk);
    #1;
    rst   = r;
    e.en  = '0;
    e.gr  = '0;
    e.sel = '0;
    bus.out_ready = rdy;
    if (r) begin
      model_reset();
      bus.req_valid = '0;
      bus.req_dst   = '0;
      bus.req_tail  = '0;
      exp_q.push_back(e);
      return;
    end
    for (int i = 0; i < int'(NI); i++) begin
      v[i] = pres[i] && (fq[i].size() > 0);
      d[i] = v[i] ? fq[i][0].dst : 0;
      t[i] = v[i] ? fq[i][0].tail : 1'b0;
      bus.req_valid[i] = v[i];
      bus.req_dst[i]   = DST_W'(d[i]);
      bus.req_tail[i]  = t[i];
    end
    for (int o = 0; o < int'(NO); o++) begin
      if (lock_own[o] >= 0) begin
        w = lock_own[o];
        e.sel[o] = SEL_W'(w);
        if (v[w] && d[w] == o && rdy[o]) begin
          e.en[o] = 1'b1;
          e.gr[w] = 1'b1;
          if (t[w]) begin
            lock_own[o] = -1;
            last_srv[o] = w;
          end
        end
      end else begin
        w = -1;
        for (int j = 1; j <= int'(NI); j++) begin
          c = (last_srv[o] + j) % int'(NI);
          if (w < 0 && v[c] && d[c] == o) w = c;
        end
        if (w >= 0 && rdy[o]) begin
          e.en[o]  = 1'b1;
          e.sel[o] = SEL_W'(w);
          e.gr[w]  = 1'b1;
          if (t[w]) last_srv[o] = w;
          else      lock_own[o] = w;
        end
      end
    end
    exp_q.push_back(e);
    for (int i = 0; i < int'(NI); i++) begin
      if (e.gr[i]) begin
        void'(fq[i].pop_front());
        age[i] = 0;
      end else if (v[i] && d[i] >= int'(NO)) begin
        // Unroutable flits are withdrawn by the source after a short wait.
        age[i]++;
        if (age[i] >= 3) begin
          void'(fq[i].pop_front());
          age[i] = 0;
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (pending() > 0 && n < 300) begin
      step(1'b0, '1, '1);
      n++;
    end
    chk("drain_pending", 32'(pending()), 32'd0);
  endtask

  // Compare every presented response against the oldest prediction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("enable", 32'(bus.enable), 32'(mon_e.en));
      chk("grant",  32'(bus.grant),  32'(mon_e.gr));
      chk("sel",    32'(bus.sel),    32'(mon_e.sel));
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_dst   = '0;
    bus.req_tail  = '0;
    bus.out_ready = '0;
    model_reset();
    repeat (2) step(1'b1, '1, '1);

    // Single-flit packets from inputs 0, 2, 4 to output 1.
    add_pkt(0, 1, 1); add_pkt(2, 1, 1); add_pkt(4, 1, 1);
    drain();

    // Input 3 locks output 2 for 4 flits while input 1 also contends.
    step(1'b1, '1, '1);
    add_pkt(3, 2, 4); add_pkt(1, 2, 1); add_pkt(1, 2, 1);
    drain();

    // Output 2 stalls for two cycles mid-packet.
    step(1'b1, '1, '1);
    add_pkt(3, 2, 4);
    for (int c = 0; c < 8; c++) step(1'b0, (c == 2 || c == 3) ? 5'b11011 : 5'b11111, '1);
    drain();

    // All five inputs to distinct outputs at once.
    step(1'b1, '1, '1);
    for (int i = 0; i < int'(NI); i++) add_pkt(i, i, 1);
    drain();

    // Reset while output 0 is locked to input 2 mid-packet.
    step(1'b1, '1, '1);
    add_pkt(2, 0, 5);
    step(1'b0, '1, '1);
    step(1'b0, '1, '1);
    step(1'b1, '1, '1);
    add_pkt(0, 0, 1);
    drain();

    // Out-of-range destination alongside legal traffic.
    step(1'b1, '1, '1);
    add_pkt(1, int'(NO), 1); add_pkt(0, 3, 2); add_pkt(4, 1, 1);
    drain();

    // Randomized traffic with bubbles, back-pressure and occasional reset.
    step(1'b1, '1, '1);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int i = 0; i < int'(NI); i++) begin
        if (fq[i].size() < 2 && $urandom_range(0, 3) == 0)
          add_pkt(i, ($urandom_range(0, 19) == 0) ? int'(NO) : int'($urandom_range(0, NO - 1)),
                  int'($urandom_range(1, 4)));
      end
      step(($urandom_range(0, 299) == 0), NO'($urandom | $urandom), NI'($urandom | $urandom));
    end
    drain();
    step(1'b0, '1, '1);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
